// File: rtl/stream_demux_1_4_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Channel count, channel index type and transfer-counter width live here.
package stream_demux_1_4_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Bundle of the upstream port and the four downstream channels of stream_demux_1_4.
// Every port uses valid/ready: a transfer happens on a rising edge where both are high.
// Ready never depends on valid, and data is held stable while valid is high and ready is low.
interface stream_demux_1_4_if
    import stream_demux_1_4_pkg::*;
#(
    parameter int W = 4
);

    logic             in_valid;
    logic [W-1:0]     in_data;
    ch_idx_t          in_sel;
    logic             in_ready;

    logic             out_valid0;
    logic             out_valid1;
    logic             out_valid2;
    logic             out_valid3;
    logic [W-1:0]     out_data0;
    logic [W-1:0]     out_data1;
    logic [W-1:0]     out_data2;
    logic [W-1:0]     out_data3;
    logic             out_ready0;
    logic             out_ready1;
    logic             out_ready2;
    logic             out_ready3;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic [CNT_W-1:0] cnt3;

    modport slave (
        input  in_valid, in_data, in_sel,
        output in_ready,
        output out_valid0, out_valid1, out_valid2, out_valid3,
        output out_data0, out_data1, out_data2, out_data3,
        input  out_ready0, out_ready1, out_ready2, out_ready3,
        output cnt0, cnt1, cnt2, cnt3
    );

    modport master (
        output in_valid, in_data, in_sel,
        input  in_ready,
        input  out_valid0, out_valid1, out_valid2, out_valid3,
        input  out_data0, out_data1, out_data2, out_data3,
        output out_ready0, out_ready1, out_ready2, out_ready3,
        input  cnt0, cnt1, cnt2, cnt3
    );

endinterface

// File: rtl/stream_demux_1_4_slot.sv
// stream_slot: single-entry holding register for one output channel,
// with a wrapping count of completed output transfers.
module stream_slot
    import stream_demux_1_4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             rdy,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] cnt
);

    logic full;
    logic xfer;

    assign xfer  = full && rdy;
    assign valid = full;

    // A load in the same cycle as a transfer refills the slot, so full stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
            cnt  <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                data <= load_data;
            end else if (xfer) begin
                full <= 1'b0;
            end
            if (xfer) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer: routes each upstream item to the channel named
// by in_sel; each channel buffers one item and drains on its own ready.
module stream_demux_1_4
    import stream_demux_1_4_pkg::*;
#(
    parameter int W = 4
) (
    input logic               clk,
    input logic               rst,
    stream_demux_1_4_if.slave bus
);

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] rdy;
    logic [NUM_CH-1:0] full;
    logic [W-1:0]      slot_data [NUM_CH];
    logic [CNT_W-1:0]  slot_cnt  [NUM_CH];

    assign rdy = {bus.out_ready3, bus.out_ready2, bus.out_ready1, bus.out_ready0};

    // The selected slot can take a word if empty or if it is emptying this cycle.
    assign bus.in_ready = !full[bus.in_sel] || rdy[bus.in_sel];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        assign load[i] = bus.in_valid && bus.in_ready && (bus.in_sel == ch_idx_t'(i));

        stream_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (bus.in_data),
            .rdy       (rdy[i]),
            .valid     (full[i]),
            .data      (slot_data[i]),
            .cnt       (slot_cnt[i])
        );
    end

    assign bus.out_valid0 = full[0];
    assign bus.out_valid1 = full[1];
    assign bus.out_valid2 = full[2];
    assign bus.out_valid3 = full[3];

    assign bus.out_data0  = slot_data[0];
    assign bus.out_data1  = slot_data[1];
    assign bus.out_data2  = slot_data[2];
    assign bus.out_data3  = slot_data[3];

    assign bus.cnt0       = slot_cnt[0];
    assign bus.cnt1       = slot_cnt[1];
    assign bus.cnt2       = slot_cnt[2];
    assign bus.cnt3       = slot_cnt[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed bench for stream_demux_1_4: routing, backpressure, streaming,
// channel independence, counter wrap and asynchronous reset mid-stream.
module tb_stream_demux_1_4;
    import stream_demux_1_4_pkg::*;

    localparam int W = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_demux_1_4_if #(.W(W)) bus();

    stream_demux_1_4 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0]       rdy;
    logic [3:0]       vld;
    logic [W-1:0]     dat [4];
    logic [CNT_W-1:0] cnt [4];

    assign bus.out_ready0 = rdy[0];
    assign bus.out_ready1 = rdy[1];
    assign bus.out_ready2 = rdy[2];
    assign bus.out_ready3 = rdy[3];
    assign vld    = {bus.out_valid3, bus.out_valid2, bus.out_valid1, bus.out_valid0};
    assign dat[0] = bus.out_data0;
    assign dat[1] = bus.out_data1;
    assign dat[2] = bus.out_data2;
    assign dat[3] = bus.out_data3;
    assign cnt[0] = bus.cnt0;
    assign cnt[1] = bus.cnt1;
    assign cnt[2] = bus.cnt2;
    assign cnt[3] = bus.cnt3;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'($urandom_range(0, 3));
        bus.in_data  = W'($urandom_range(0, (1 << W) - 1));
    endtask

    // scoreboard: per-channel expected order, popped on every observed output transfer
    logic [W-1:0] exp_q [4][$];

    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) exp_q[c].delete();
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (vld[c] && rdy[c]) begin
                    if (exp_q[c].size() == 0)
                        check_eq($sformatf("sb_extra_ch%0d", c), 32'd1, 32'd0);
                    else
                        check_eq($sformatf("sb_order_ch%0d", c), 32'(dat[c]), 32'(exp_q[c].pop_front()));
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q[bus.in_sel].push_back(bus.in_data);
        end
    end

    initial begin
        rst = 1'b1;
        rdy = 4'hf;
        idle();
        #2;
        check_eq("rst_valid", 32'(vld), 32'h0);
        check_eq("rst_cnt2", 32'(cnt[2]), 32'h0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;

        // single routing to channel 2
        send(2'd2, 4'hc);
        #1 check_eq("route_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        check_eq("route_valid", 32'(vld), 32'h4);
        check_eq("route_data2", 32'(dat[2]), 32'hc);
        tick();
        check_eq("route_cnt2", 32'(cnt[2]), 32'h1);
        check_eq("route_valid_clr", 32'(vld), 32'h0);

        // backpressure on channel 1
        rdy = 4'b1101;
        send(2'd1, 4'ha);
        #1 check_eq("bp_first_ready", 32'(bus.in_ready), 32'h1);
        tick();
        send(2'd1, 4'hb);
        #1 check_eq("bp_second_blocked", 32'(bus.in_ready), 32'h0);
        check_eq("bp_hold_data", 32'(dat[1]), 32'ha);
        tick();
        check_eq("bp_hold_data2", 32'(dat[1]), 32'ha);
        check_eq("bp_hold_valid", 32'(vld[1]), 32'h1);
        check_eq("bp_no_cnt", 32'(cnt[1]), 32'h0);
        rdy = 4'hf;
        #1 check_eq("bp_release_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        check_eq("bp_next_data", 32'(dat[1]), 32'hb);
        check_eq("bp_next_valid", 32'(vld[1]), 32'h1);
        check_eq("bp_cnt_a", 32'(cnt[1]), 32'h1);
        tick();
        check_eq("bp_cnt_b", 32'(cnt[1]), 32'h2);
        check_eq("bp_drained", 32'(vld[1]), 32'h0);

        // streaming 1..10 on channel 0
        for (int k = 1; k <= 10; k++) begin
            send(2'd0, W'(k));
            #1 check_eq("stream_ready", 32'(bus.in_ready), 32'h1);
            if (k > 1) check_eq("stream_data", 32'(dat[0]), 32'(k - 1));
            tick();
        end
        idle();
        check_eq("stream_last", 32'(dat[0]), 32'ha);
        check_eq("stream_last_valid", 32'(vld[0]), 32'h1);
        tick();
        check_eq("stream_cnt0", 32'(cnt[0]), 32'd10);

        // independence: channel 3 blocked and full, channel 0 still flows
        rdy = 4'b0111;
        send(2'd3, 4'h5);
        tick();
        send(2'd0, 4'h6);
        #1 check_eq("indep_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        check_eq("indep_valid0", 32'(vld[0]), 32'h1);
        check_eq("indep_data0", 32'(dat[0]), 32'h6);
        check_eq("indep_valid3", 32'(vld[3]), 32'h1);
        check_eq("indep_data3", 32'(dat[3]), 32'h5);
        tick();
        check_eq("indep_cnt0", 32'(cnt[0]), 32'd11);
        check_eq("indep_hold3", 32'(dat[3]), 32'h5);
        check_eq("indep_cnt3", 32'(cnt[3]), 32'd0);
        rdy = 4'hf;
        tick();
        check_eq("indep_cnt3_after", 32'(cnt[3]), 32'd1);
        check_eq("indep_valid3_clr", 32'(vld[3]), 32'h0);

        // reset mid-stream with all channels full
        rdy = 4'h0;
        for (int c = 0; c < 4; c++) begin
            send(2'(c), W'(c + 8));
            tick();
        end
        idle();
        check_eq("mid_all_full", 32'(vld), 32'hf);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(vld), 32'h0);
        check_eq("mid_rst_cnt0", 32'(cnt[0]), 32'h0);
        check_eq("mid_rst_cnt1", 32'(cnt[1]), 32'h0);
        check_eq("mid_rst_cnt3", 32'(cnt[3]), 32'h0);
        check_eq("mid_rst_data2", 32'(dat[2]), 32'h0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        rst = 1'b0;
        #1 check_eq("mid_post_valid", 32'(vld), 32'h0);
        rdy = 4'hf;

        // counter wrap on channel 1
        send(2'd0, 4'h3);
        tick();
        idle();
        tick();
        check_eq("wrap_pre_cnt0", 32'(cnt[0]), 32'd1);
        for (int i = 0; i < 256; i++) begin
            send(2'd1, W'(i));
            tick();
        end
        idle();
        check_eq("wrap_cnt1_255", 32'(cnt[1]), 32'd255);
        tick();
        check_eq("wrap_cnt1_0", 32'(cnt[1]), 32'd0);
        check_eq("wrap_cnt0_kept", 32'(cnt[0]), 32'd1);
        check_eq("wrap_cnt2_kept", 32'(cnt[2]), 32'd0);
        check_eq("wrap_cnt3_kept", 32'(cnt[3]), 32'd0);

        tick();
        tick();
        for (int c = 0; c < 4; c++)
            check_eq($sformatf("sb_empty_ch%0d", c), 32'(exp_q[c].size()), 32'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
